playback_sequencer: RTL

Parametrised phrase sequencer that owns playhead timing and per-line entry fetch for NUM_CH channels. It reads phrase entries from a synchronous phrase RAM, double-buffers the next line, and presents all channel entries atomically on each tempo tick. It sits between phrase memory and the DDS/mixer channel bank. It adds pause-without-reset, one-shot/loop end handling and stop/start control.

---
 rtl/playback_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/playback_sequencer.sv
// Phrase playback sequencer: fetches NUM_CH entries per line from a synchronous
// phrase RAM into a shadow buffer and presents them atomically on each tempo tick.
module playback_sequencer #(
  parameter int unsigned NUM_CH                = 4,
  parameter int unsigned LINES                 = 16,
  parameter int unsigned ENTRY_W               = 16,
  parameter int unsigned TEMPO_W               = 9,
  parameter int unsigned ACC_WIDTH             = 48,
  parameter int unsigned TEMPO_SCALE           = 46912,
  parameter logic [ENTRY_W-1:0] SILENT_ENTRY   = 'hFF00,
  localparam int unsigned CH_W                 = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned LINE_W               = $clog2(LINES)
) (
  input  logic                        clk,
  input  logic                        reset_active_high,
  input  logic [TEMPO_W-1:0]          tempo,
  input  logic                        loop_enable,
  input  logic                        play_enable,
  input  logic                        start,
  input  logic                        stop,
  output logic                        rd_en,
  output logic [LINE_W+CH_W-1:0]      rd_addr,
  input  logic [ENTRY_W-1:0]          rd_data,
  output logic [NUM_CH*ENTRY_W-1:0]   entry_out,
  output logic [LINE_W-1:0]           line_count,
  output logic                        line_strobe,
  output logic                        active,
  output logic                        done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH0, S_PLAY} state_t;

  state_t                      r_state;
  logic [ACC_WIDTH-1:0]        r_acc;
  logic [ENTRY_W-1:0]          r_shadow [NUM_CH];
  logic [NUM_CH*ENTRY_W-1:0]   r_entry;
  logic [LINE_W-1:0]           r_line_count;
  logic [LINE_W-1:0]           r_fetch_line;
  logic                        r_rd_en;
  logic [CH_W-1:0]             r_rd_ch;
  logic                        r_cap_vld;
  logic [CH_W-1:0]             r_cap_ch;
  logic                        r_launch;
  logic                        r_busy;
  logic                        r_pending;
  logic                        r_commit_req;
  logic                        r_line_strobe;
  logic                        r_active;
  logic                        r_done;

  logic [ACC_WIDTH-1:0]        w_inc;
  logic [ACC_WIDTH:0]          w_sum;
  logic                        w_tick;
  logic                        w_end;
  logic                        w_cap_last;
  logic                        w_commit;

  // Tempo accumulator: a tick is the carry out of acc + tempo*scale.
  assign w_inc      = ACC_WIDTH'(tempo) * ACC_WIDTH'(TEMPO_SCALE);
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_inc};
  assign w_tick     = (r_state == S_PLAY) && play_enable && w_sum[ACC_WIDTH];
  assign w_end      = w_tick && (r_line_count == LINE_W'(LINES - 1)) && !loop_enable;
  assign w_cap_last = r_cap_vld && (r_cap_ch == CH_W'(NUM_CH - 1));
  // A pending or first-line commit request beats a fresh tick; a tick during a fetch waits.
  assign w_commit   = ((r_state == S_FETCH0) && r_commit_req) ||
                      ((r_state == S_PLAY) && !w_end &&
                       (r_commit_req || (w_tick && !r_busy)));

  always_ff @(posedge clk or posedge reset_active_high) begin
    if (reset_active_high) begin
      r_state       <= S_IDLE;
      r_acc         <= '0;
      for (int c = 0; c < NUM_CH; c++) r_shadow[c] <= '0;
      r_entry       <= {NUM_CH{SILENT_ENTRY}};
      r_line_count  <= '0;
      r_fetch_line  <= '0;
      r_rd_en       <= 1'b0;
      r_rd_ch       <= '0;
      r_cap_vld     <= 1'b0;
      r_cap_ch      <= '0;
      r_launch      <= 1'b0;
      r_busy        <= 1'b0;
      r_pending     <= 1'b0;
      r_commit_req  <= 1'b0;
      r_line_strobe <= 1'b0;
      r_active      <= 1'b0;
      r_done        <= 1'b0;
    end else if (stop || w_end) begin
      r_state       <= S_IDLE;
      r_acc         <= '0;
      for (int c = 0; c < NUM_CH; c++) r_shadow[c] <= '0;
      r_entry       <= {NUM_CH{SILENT_ENTRY}};
      r_line_count  <= '0;
      r_fetch_line  <= '0;
      r_rd_en       <= 1'b0;
      r_rd_ch       <= '0;
      r_cap_vld     <= 1'b0;
      r_cap_ch      <= '0;
      r_launch      <= 1'b0;
      r_busy        <= 1'b0;
      r_pending     <= 1'b0;
      r_commit_req  <= 1'b0;
      r_line_strobe <= 1'b0;
      r_active      <= 1'b0;
      r_done        <= !stop;
    end else begin
      r_line_strobe <= 1'b0;
      r_done        <= 1'b0;

      // Fetch engine: issue NUM_CH reads, capture each one cycle later.
      if (r_launch) begin
        r_launch <= 1'b0;
        r_rd_en  <= 1'b1;
        r_rd_ch  <= '0;
      end else if (r_rd_en) begin
        if (r_rd_ch == CH_W'(NUM_CH - 1)) r_rd_en <= 1'b0;
        else                              r_rd_ch <= r_rd_ch + CH_W'(1);
      end
      r_cap_vld <= r_rd_en;
      r_cap_ch  <= r_rd_ch;
      if (r_cap_vld) r_shadow[r_cap_ch] <= rd_data;
      if (w_cap_last) r_busy <= 1'b0;

      if (r_state == S_PLAY && play_enable) r_acc <= w_sum[ACC_WIDTH-1:0];

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_FETCH0;
            r_active     <= 1'b1;
            r_acc        <= '0;
            r_fetch_line <= '0;
            r_rd_en      <= 1'b1;
            r_rd_ch      <= '0;
            r_busy       <= 1'b1;
          end
        end
        S_FETCH0, S_PLAY: begin
          if (w_commit) begin
            for (int c = 0; c < NUM_CH; c++) r_entry[c*ENTRY_W +: ENTRY_W] <= r_shadow[c];
            r_line_count  <= r_fetch_line;
            r_fetch_line  <= r_fetch_line + LINE_W'(1);
            r_line_strobe <= 1'b1;
            r_busy        <= 1'b1;
            r_launch      <= 1'b1;
            r_commit_req  <= 1'b0;
            r_pending     <= 1'b0;
            r_state       <= S_PLAY;
          end else if (w_cap_last && (r_state == S_FETCH0 || r_pending || w_tick)) begin
            r_commit_req <= 1'b1;
            r_pending    <= 1'b0;
          end else if (w_tick && r_busy) begin
            r_pending <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_en       = r_rd_en;
  assign rd_addr     = {r_fetch_line, r_rd_ch};
  assign entry_out   = r_entry;
  assign line_count  = r_line_count;
  assign line_strobe = r_line_strobe;
  assign active      = r_active;
  assign done        = r_done;

endmodule
